// File: rtl/foo_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : foo_lane_arbiter
// Description : Round-robin arbiter merging N valid/data request lanes into a
//               single registered valid/ready output stream. One transfer per
//               cycle while out_ready is held high; the pointer advances only
//               on a grant.
// Revision    : 1.0 - initial release
// ============================================================================
module foo_lane_arbiter #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int LW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [LW-1:0]  out_lane,
    input  logic           out_ready,
    output logic [15:0]    xfer_count
);

    localparam logic [LW-1:0] c_last_lane = LW'(N - 1);

    logic [LW-1:0] r_rr_ptr;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [LW-1:0] r_out_lane;
    logic [15:0]   r_xfer_count;

    logic          w_load_en;
    logic          w_found;
    logic [LW-1:0] w_winner;
    logic [W-1:0]  w_win_data;
    logic [LW-1:0] w_next_ptr;
    logic          w_grant;

    // Output register may accept a new word when empty or being drained now.
    assign w_load_en = !r_out_valid || out_ready;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_data = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && in_valid[(int'(r_rr_ptr) + k) % N]) begin
                w_found    = 1'b1;
                w_winner   = LW'((int'(r_rr_ptr) + k) % N);
                w_win_data = in_data[((int'(r_rr_ptr) + k) % N) * W +: W];
            end
        end
    end

    // Lane after the winner, wrapping explicitly so non-power-of-two N works.
    assign w_next_ptr = (w_winner == c_last_lane) ? '0 : w_winner + 1'b1;

    // A grant happens whenever a winner exists and the output can take it.
    assign w_grant = !rst && w_load_en && w_found;

    // One-hot accept back to the winning lane only.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_grant && (w_winner == LW'(i));
        end
    end

    // Output register, round-robin pointer and load/drain control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_out_lane  <= w_winner;
                r_rr_ptr    <= w_next_ptr;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Count completed downstream handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_lane   = r_out_lane;
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_foo_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_foo_lane_arbiter
// Description : Self-checking bench for foo_lane_arbiter: directed scenarios
//               plus randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_foo_lane_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LW = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [LW-1:0]  out_lane;
    logic           out_ready;
    logic [15:0]    xfer_count;

    int n_checks;
    int n_errors;

    // Reference model state
    logic           m_valid;
    logic [W-1:0]   m_data;
    int             m_lane;
    int             m_ptr;
    int             m_cnt;

    foo_lane_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requesting lane with the smallest circular distance from the pointer.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - ptr + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // One clock: drive inputs, check against model, advance model, end #1 after posedge.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        int            win;
        logic          load;
        logic [N-1:0]  exp_rdy;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        win  = pick(v, m_ptr);
        load = !m_valid || ordy;
        exp_rdy = '0;
        if (!r && load && win >= 0) exp_rdy[win] = 1'b1;
        check_eq("in_ready",   32'(in_ready),   32'(exp_rdy));
        check_eq("out_valid",  32'(out_valid),  32'(m_valid));
        if (m_valid) begin
            check_eq("out_data", 32'(out_data), 32'(m_data));
            check_eq("out_lane", 32'(out_lane), 32'(m_lane));
        end
        check_eq("xfer_count", 32'(xfer_count), 32'(m_cnt));
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_lane  = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else begin
            if (m_valid && ordy) m_cnt = (m_cnt + 1) % 65536;
            if (load) begin
                if (win >= 0) begin
                    m_valid = 1'b1;
                    m_data  = d[win*W +: W];
                    m_lane  = win;
                    m_ptr   = (win + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    initial begin
        logic [N*W-1:0] d;
        n_checks  = 0;
        n_errors  = 0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_lane    = 0;
        m_ptr     = 0;
        m_cnt     = 0;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held two cycles with every lane requesting
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_xfer",      32'(xfer_count), 32'd0);

        // Round-robin over all lanes, first grant to lane 0
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b1111, rand_data(), 1'b1);
            check_eq("rr_lane", 32'(out_lane), 32'(i % N));
            check_eq("rr_valid", 32'(out_valid), 32'd1);
        end
        step(1'b0, 4'b0000, rand_data(), 1'b1);
        check_eq("rr_xfer6", 32'(xfer_count), 32'd6);

        // Sparse requests skip idle lanes
        step(1'b1, 4'b0000, '0, 1'b1);
        step(1'b0, 4'b1010, rand_data(), 1'b1);
        check_eq("sparse_1", 32'(out_lane), 32'd1);
        step(1'b0, 4'b1010, rand_data(), 1'b1);
        check_eq("sparse_3", 32'(out_lane), 32'd3);
        step(1'b0, 4'b1010, rand_data(), 1'b1);
        check_eq("sparse_1b", 32'(out_lane), 32'd1);

        // Backpressure on a captured lane-2 word
        step(1'b1, 4'b0000, '0, 1'b1);
        d = rand_data();
        d[2*W +: W] = 8'hA5;
        step(1'b0, 4'b0100, d, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, rand_data(), 1'b0);
            check_eq("bp_data", 32'(out_data), 32'hA5);
            check_eq("bp_lane", 32'(out_lane), 32'd2);
        end
        step(1'b0, 4'b1111, rand_data(), 1'b1);
        check_eq("bp_next_lane", 32'(out_lane), 32'd3);
        check_eq("bp_xfer", 32'(xfer_count), 32'd1);

        // Reset while stalled drops the held word
        step(1'b1, 4'b0000, '0, 1'b1);
        d = rand_data();
        d[0 +: W] = 8'h3C;
        step(1'b0, 4'b0001, d, 1'b1);
        step(1'b0, 4'b0000, rand_data(), 1'b0);
        check_eq("stall_data", 32'(out_data), 32'h3C);
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data",  32'(out_data),  32'd0);
        check_eq("mid_rst_xfer",  32'(xfer_count), 32'd0);
        step(1'b0, 4'b1110, rand_data(), 1'b1);
        check_eq("mid_rst_ptr", 32'(out_lane), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) == 0), N'($urandom), rand_data(),
                 ($urandom_range(0, 3) != 0));
        end

        // Counter wrap: saturate traffic until the count rolls over
        step(1'b0, 4'b1111, rand_data(), 1'b1);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            step(1'b0, 4'b1111, rand_data(), 1'b1);
        end
        check_eq("pre_wrap", 32'(xfer_count), 32'hFFFF);
        step(1'b0, 4'b1111, rand_data(), 1'b1);
        check_eq("wrap", 32'(xfer_count), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
